// File: rtl/mcp_arb_pkg.sv
// Shared types for the multi-cycle-path TX arbiter: FSM state encoding and
// the requester-index width helper.
package mcp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2,
    HOLD     = 2'd3
  } arb_state_e;

  function automatic int mcp_arb_idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync2_pgen.sv
// Two-flop synchronizer for a toggle signal plus an edge-to-pulse stage.
// The chain has no reset so a toggle made while the system is held in reset
// is absorbed rather than replayed as a stray edge after release.
module sync2_pgen (
  input  logic clk,
  input  logic din,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    s1 <= din;
    s2 <= s1;
    s3 <= s2;
  end

  assign pulse = s2 ^ s3;

endmodule

// File: rtl/mcp_tx_arbiter.sv
// Round-robin arbiter feeding one multi-cycle-path crossing: issue, wait for
// the toggle ack, hold GAP cycles. Optional ack timeout under MCP_ARB_TIMEOUT_EN.
module mcp_tx_arbiter
  import mcp_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*DW-1:0]            req_data,
  output logic [NREQ-1:0]               req_ready,
  output logic                          tx_en,
  output logic [DW-1:0]                 tx_data,
  output logic [mcp_arb_idw(NREQ)-1:0]  tx_id,
  input  logic                          ack_tgl,
  output logic                          busy,
  output logic                          err
);

  localparam int         IDW       = mcp_arb_idw(NREQ);
  localparam logic [3:0] HOLD_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  arb_state_e               state, state_nxt;
  logic [IDW-1:0]           last_grant, win, pick, idx;
  logic                     found;
  logic [3:0]               hold_cnt;
  logic                     ack_pulse;
  logic                     to_hit;
  logic [NREQ-1:0][DW-1:0]  data_arr;

  assign data_arr = req_data;

  sync2_pgen u_ack_sync (
    .clk   (clk),
    .din   (ack_tgl),
    .pulse (ack_pulse)
  );

  // Rotating search starting one past the last grant.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = last_grant;
    for (int k = 0; k < NREQ; k++) begin
      idx = (idx == IDW'(NREQ - 1)) ? '0 : idx + IDW'(1);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

`ifdef MCP_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                to_cnt <= '0;
    else if (state == WAIT_ACK) to_cnt <= to_cnt + TW'(1);
    else                       to_cnt <= '0;
  end

  assign to_hit = (state == WAIT_ACK) && (to_cnt == TW'(TIMEOUT - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    tx_en     = 1'b0;
    req_ready = '0;
    err       = 1'b0;
    case (state)
      IDLE:     if (found) state_nxt = SEND;
      SEND: begin
        tx_en          = 1'b1;
        req_ready[win] = 1'b1;
        state_nxt      = WAIT_ACK;
      end
      // Ack wins over a coincident timeout, so err only fires on a true miss.
      WAIT_ACK: begin
        if (ack_pulse) begin
          state_nxt = HOLD;
        end else if (to_hit) begin
          err       = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD:     if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDW'(NREQ - 1);
      win        <= '0;
      tx_data    <= '0;
      hold_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= (state == HOLD) ? hold_cnt + 4'd1 : 4'd0;
      if (state == IDLE && found) begin
        win        <= pick;
        last_grant <= pick;
        tx_data    <= data_arr[pick];
      end
    end
  end

  assign tx_id = win;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mcp_tx_arbiter.sv
// Directed bench for mcp_tx_arbiter: two instances (default GAP, and GAP=3 /
// TIMEOUT=8) sharing clock and reset; timeout checks follow MCP_ARB_TIMEOUT_EN.
module tb_mcp_tx_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   rv1, rr1, rv2, rr2;
  logic [127:0] rd1, rd2;
  logic         ten1, ten2, ack1, ack2, busy1, busy2, err1, err2;
  logic [31:0]  td1, td2;
  logic [1:0]   tid1, tid2;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  mcp_tx_arbiter #(.NREQ(4), .DW(32), .GAP(2), .TIMEOUT(255)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_data(rd1), .req_ready(rr1),
    .tx_en(ten1), .tx_data(td1), .tx_id(tid1), .ack_tgl(ack1), .busy(busy1), .err(err1));

  mcp_tx_arbiter #(.NREQ(4), .DW(32), .GAP(3), .TIMEOUT(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv2), .req_data(rd2), .req_ready(rr2),
    .tx_en(ten2), .tx_data(td2), .tx_id(tid2), .ack_tgl(ack2), .busy(busy2), .err(err2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tx(input int d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((d == 1) ? ten1 : ten2) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(input int d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!((d == 1) ? busy1 : busy2)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rv1 = '0; rv2 = '0; rd1 = '0; rd2 = '0; ack1 = 1'b0; ack2 = 1'b0;
    repeat (4) tick();
    checks++; if ({ten1, rr1, tid1, busy1, err1} !== 9'd0) begin errors++;
      $display("FAIL reset_ctl: got %0h want 0", {ten1, rr1, tid1, busy1, err1}); end
    checks++; if (td1 !== 32'd0) begin errors++;
      $display("FAIL reset_data: got %0h want 0", td1); end
    checks++; if ({ten2, rr2, busy2, err2} !== 7'd0) begin errors++;
      $display("FAIL reset_ctl2: got %0h want 0", {ten2, rr2, busy2, err2}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int n, pulses;
    rv1 = 4'b0001;
    rd1[31:0] = 32'hA5A5_A5A5;
    tick();
    checks++; if (ten1 !== 1'b1) begin errors++; $display("FAIL single_ten: got %0b want 1", ten1); end
    checks++; if (tid1 !== 2'd0) begin errors++; $display("FAIL single_id: got %0d want 0", tid1); end
    checks++; if (td1 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL single_data: got %0h want a5a5a5a5", td1); end
    checks++; if (rr1 !== 4'b0001) begin errors++; $display("FAIL single_ready: got %0b want 0001", rr1); end
    rv1 = 4'b0000;
    tick();
    checks++; if ({ten1, busy1} !== 2'b01) begin errors++;
      $display("FAIL single_after: got ten/busy %0b want 01", {ten1, busy1}); end
    tick(); tick();
    ack1 = ~ack1;
    n = 0; pulses = 0;
    while (busy1 && n < 30) begin
      tick();
      n++;
      if (ten1) pulses++;
    end
    checks++; if (n !== 5) begin errors++; $display("FAIL single_ack_to_idle: got %0d want 5", n); end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL single_extra_tx: got %0d want 0", pulses); end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [1:0]  exp_id;
    logic [3:0]  exp_rr;
    logic [31:0] exp_d;
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) rd1[i*32 +: 32] = 32'h1000_0000 + 32'(i);
    rv1 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_id = 2'(k % 4);
      exp_rr = 4'b0001 << exp_id;
      exp_d  = 32'h1000_0000 + 32'(k % 4);
      wait_tx(1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_timeout: got no tx_en want issue %0d", k); end
      checks++; if (tid1 !== exp_id) begin errors++; $display("FAIL rr_id: got %0d want %0d", tid1, exp_id); end
      checks++; if (rr1 !== exp_rr) begin errors++; $display("FAIL rr_ready: got %0b want %0b", rr1, exp_rr); end
      checks++; if (td1 !== exp_d) begin errors++; $display("FAIL rr_data: got %0h want %0h", td1, exp_d); end
      tick();
      checks++; if (ten1 !== 1'b0) begin errors++; $display("FAIL rr_back_to_back: got %0b want 0", ten1); end
      ack1 = ~ack1;
      if (k == 4) rv1 = 4'b0000;
    end
    wait_idle(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_idle: got busy want idle"); end
  endtask

  task automatic test_gap_spacing();
    bit ok;
    int n, idle_cyc;
    rv2 = 4'b0010;
    rd2[63:32] = 32'h5555_0001;
    wait_tx(2, ok);
    checks++; if (!ok || tid2 !== 2'd1) begin errors++; $display("FAIL gap_first: got id %0d ok %0b want 1", tid2, ok); end
    tick();
    ack2 = ~ack2;
    n = 1; idle_cyc = 0;
    while (!ten2 && n < 40) begin
      tick();
      n++;
      if (!busy2) idle_cyc++;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL gap_spacing: got %0d want 8", n); end
    checks++; if (idle_cyc !== 1) begin errors++; $display("FAIL gap_idle_cycles: got %0d want 1", idle_cyc); end
    checks++; if (td2 !== 32'h5555_0001) begin errors++; $display("FAIL gap_data: got %0h want 55550001", td2); end
    rv2 = 4'b0000;
    tick();
    ack2 = ~ack2;
    wait_idle(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL gap_idle: got busy want idle"); end
  endtask

  task automatic test_timeout();
    bit ok;
    int err_cnt, err_at;
    rv2 = 4'b0100;
    rd2[95:64] = 32'h7777_0002;
    wait_tx(2, ok);
    rv2 = 4'b0000;
    err_cnt = 0; err_at = -1;
`ifdef MCP_ARB_TIMEOUT_EN
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (err2) begin err_cnt++; err_at = c; end
    end
    checks++; if (err_at !== 8) begin errors++; $display("FAIL to_err_cycle: got %0d want 8", err_at); end
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL to_err_count: got %0d want 1", err_cnt); end
    tick();
    checks++; if ({busy2, err2} !== 2'b10) begin errors++; $display("FAIL to_hold: got busy/err %0b want 10", {busy2, err2}); end
    tick(); tick(); tick();
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL to_idle: got %0b want 0", busy2); end
`else
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (err2) err_cnt++;
    end
    checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL noto_busy: got %0b want 1", busy2); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL noto_err: got %0d want 0", err_cnt); end
    ack2 = ~ack2;
    wait_idle(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL noto_idle: got busy want idle"); end
`endif
  endtask

  task automatic test_ack_priority();
    bit ok;
    int err_cnt;
    rv2 = 4'b0001;
    rd2[31:0] = 32'h9999_0000;
    wait_tx(2, ok);
    checks++; if (!ok || tid2 !== 2'd0) begin errors++; $display("FAIL prio_issue: got id %0d ok %0b want 0", tid2, ok); end
    rv2 = 4'b0000;
    err_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (err2) err_cnt++;
      if (c == 6) ack2 = ~ack2;
      if (c == 11) begin
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL prio_hold: got %0b want 1", busy2); end
      end
    end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL prio_idle: got %0b want 0", busy2); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL prio_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int busy_cnt;
    rv1 = 4'b0100;
    rd1[95:64] = 32'hCAFE_0002;
    wait_tx(1, ok);
    checks++; if (!ok || tid1 !== 2'd2) begin errors++; $display("FAIL mid_issue: got id %0d ok %0b want 2", tid1, ok); end
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++; if ({ten1, rr1, tid1, busy1, err1} !== 9'd0) begin errors++;
      $display("FAIL mid_reset_ctl: got %0h want 0", {ten1, rr1, tid1, busy1, err1}); end
    checks++; if (td1 !== 32'd0) begin errors++; $display("FAIL mid_reset_data: got %0h want 0", td1); end
    ack1 = ~ack1;
    tick(); tick(); tick();
    rst_n = 1'b1;
    wait_tx(1, ok);
    checks++; if (!ok || tid1 !== 2'd2) begin errors++; $display("FAIL mid_reissue: got id %0d ok %0b want 2", tid1, ok); end
    checks++; if (rr1 !== 4'b0100) begin errors++; $display("FAIL mid_ready: got %0b want 0100", rr1); end
    checks++; if (td1 !== 32'hCAFE_0002) begin errors++; $display("FAIL mid_data: got %0h want cafe0002", td1); end
    rv1 = 4'b0000;
    busy_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (busy1) busy_cnt++;
    end
    checks++; if (busy_cnt !== 8) begin errors++; $display("FAIL mid_stray_ack: got %0d busy cycles want 8", busy_cnt); end
    ack1 = ~ack1;
    wait_idle(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_idle: got busy want idle"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_gap_spacing();
    test_timeout();
    test_ack_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcp_tx_arbiter.md
MCP_TX_ARBITER -- requirements
Module: mcp_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of source-domain requesters sharing one multi-cycle-path crossing (range 2..16).
REQ-002 Parameter DW, default 32: payload width per requester.
REQ-003 Parameter GAP, default 2: idle cycles enforced after each acknowledge before the next issue (0..15).
REQ-004 Parameter TIMEOUT, default 255: acknowledge wait limit in clk cycles; used only when the timeout feature is compiled in.
REQ-005 clk  in  1  sole clock; all logic is single-clock, rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 req_valid  in  NREQ  per-requester request; once high, it holds with stable data until its req_ready.
REQ-008 req_data  in  NREQ*DW  payloads; requester i occupies bits [i*DW +: DW].
REQ-009 req_ready  out  NREQ  one-hot, one-cycle accept pulse.
REQ-010 tx_en  out  1  one-cycle enable to the crossing's source side.
REQ-011 tx_data  out  DW  payload, valid while tx_en is high and held stable until the next issue.
REQ-012 tx_id  out  IDW  index of the issued requester; IDW = max(1, clog2(NREQ)).
REQ-013 ack_tgl  in  1  asynchronous toggle from the destination domain; each edge means "payload sampled".
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 err  out  1  one-cycle timeout pulse.

Function
REQ-016 FSM states: IDLE, SEND, WAIT_ACK, HOLD.
REQ-017 IDLE: any req_valid high -> latch the round-robin winner index and its payload, then go to SEND; otherwise stay.
REQ-018 Round-robin search starts at (last_grant+1) mod NREQ; last_grant resets to NREQ-1, so requester 0 wins first.
REQ-019 SEND (exactly 1 cycle): tx_en=1, req_ready[winner]=1, tx_data/tx_id = latched values, then go to WAIT_ACK.
REQ-020 Latency: request seen in IDLE at cycle t -> tx_en and req_ready at t+1.
REQ-021 WAIT_ACK: a synchronized ack_tgl edge -> go to HOLD; ack edges seen outside WAIT_ACK are discarded.
REQ-022 HOLD: count GAP cycles, then go to IDLE; with GAP=0, HOLD lasts 1 cycle.
REQ-023 Minimum issue spacing is therefore 2 + sync latency + max(GAP,1) cycles; tx_en is never high in two consecutive cycles.
REQ-024 A request arriving during busy waits; a winner already latched is not re-arbitrated.
REQ-025 Simultaneous ack edge and timeout expiry in WAIT_ACK: the ack takes priority and err stays 0.

Reset
REQ-026 While rst_n=0: state=IDLE, last_grant=NREQ-1, and req_ready, tx_en, tx_data, tx_id, busy and err all 0.
REQ-027 Reset mid-transfer abandons the transfer; the requester, which has not yet seen req_ready, re-requests after release.
REQ-028 The first synchronized ack edge after reset release is ignored unless the FSM is in WAIT_ACK.

Configuration
REQ-029 Macro MCP_ARB_TIMEOUT_EN: when defined, a counter runs in WAIT_ACK; on reaching TIMEOUT it pulses err for 1 cycle and the FSM goes to HOLD.
REQ-030 Without MCP_ARB_TIMEOUT_EN: no counter is built, err is tied 0, and WAIT_ACK waits indefinitely.

Structure
REQ-031 Shared package mcp_arb_pkg holds the state enum and the IDW width function.
REQ-032 ack_tgl synchronization and edge detection reuse the existing sync2_pgen as the single sub-module; the arbiter instantiates no other module.

Verification
REQ-033 NREQ=4, req_valid=4'b0001, data 0xA5A5A5A5, ack after 3 cycles -> one tx_en pulse at t+1, tx_data=0xA5A5A5A5, tx_id=0, req_ready=4'b0001.
REQ-034 All four valid and held, with ack each time -> issue order tx_id 0,1,2,3,0; each req_ready one-hot and aligned with tx_en.
REQ-035 GAP=3 with ack returned immediately -> at least 3 HOLD cycles between ack detection and the next IDLE; tx_en spacing as in REQ-023.
REQ-036 Macro defined, TIMEOUT=8, no ack -> err pulses once 8 cycles into WAIT_ACK, then HOLD, IDLE; without the macro, busy stays 1 and err stays 0.
REQ-037 rst_n low in WAIT_ACK, then released with requester 2 still valid -> all outputs 0 during reset; after release, requester 2 is issued and the stray ack edge is ignored.
